// File: rtl/scroll_pkg.sv
// Shared axis-mode encoding for the scroll transformer.
package scroll_pkg;

    typedef logic [1:0] mode_t;

    localparam mode_t MODE_STATIC = 2'b00;
    localparam mode_t MODE_WRAP   = 2'b01;
    localparam mode_t MODE_BOUNCE = 2'b10;

endpackage

// File: rtl/mod_m_timer.sv
// Free-running modulo-M counter; max_tick_c is high in the last count of each period.
module mod_m_timer #(
    parameter int unsigned N = 4,
    parameter int unsigned M = 10
) (
    input  logic clk,
    input  logic reset,
    output logic max_tick_c
);

    localparam logic [N-1:0] LAST = N'(M - 1);

    logic [N-1:0] count;

    // Count 0..M-1 and wrap.
    always_ff @(posedge clk) begin
        if (reset) begin
            count <= '0;
        end else if (count == LAST) begin
            count <= '0;
        end else begin
            count <= count + 1'b1;
        end
    end

    assign max_tick_c = (count == LAST);

endmodule

// File: rtl/scroll_axis.sv
// One scroll axis: pending/active offset, bounce direction and registered transform.
module scroll_axis
    import scroll_pkg::*;
#(
    parameter int unsigned CW  = 10,
    parameter int unsigned MAX = 640,
    parameter int unsigned SW  = 4
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          tick,
    input  logic          commit,
    input  mode_t         mode,
    input  logic          dir,
    input  logic [SW-1:0] step,
    input  logic          mirror,
    input  logic [CW-1:0] coord,
    output logic [CW-1:0] new_coord,
    output logic [CW-1:0] off
);

    localparam logic [CW:0] MAX_E  = (CW+1)'(MAX);
    localparam logic [CW:0] LAST_E = (CW+1)'(MAX - 1);

    logic [CW-1:0] pend;
    logic [CW-1:0] act;
    logic          bounce_down;

    logic [CW:0]        pend_e_c;
    logic [CW:0]        step_e_c;
    logic [CW:0]        sum_c;
    logic signed [CW:0] diff_c;
    logic [CW-1:0]      pend_nxt_c;
    logic               down_nxt_c;
    logic [CW:0]        coord_e_c;
    logic [CW:0]        shifted_c;
    logic [CW:0]        wrapped_c;
    logic [CW-1:0]      map_c;

    // Next pending offset for the current mode.
    always_comb begin
        pend_e_c   = {1'b0, pend};
        step_e_c   = (CW+1)'(step);
        sum_c      = pend_e_c + step_e_c;
        diff_c     = $signed(pend_e_c) - $signed(step_e_c);
        pend_nxt_c = pend;
        down_nxt_c = bounce_down;
        case (mode)
            MODE_WRAP: begin
                if (!dir) begin
                    pend_nxt_c = (sum_c >= MAX_E) ? CW'(sum_c - MAX_E) : CW'(sum_c);
                end else begin
                    pend_nxt_c = (diff_c < 0) ? CW'(diff_c + $signed(MAX_E)) : CW'(diff_c);
                end
            end
            MODE_BOUNCE: begin
                if (!bounce_down) begin
                    if (sum_c >= LAST_E) begin
                        pend_nxt_c = CW'(LAST_E);
                        down_nxt_c = 1'b1;
                    end else begin
                        pend_nxt_c = CW'(sum_c);
                    end
                end else begin
                    if (pend_e_c <= step_e_c) begin
                        pend_nxt_c = '0;
                        down_nxt_c = 1'b0;
                    end else begin
                        pend_nxt_c = CW'(pend_e_c - step_e_c);
                    end
                end
            end
            default: begin
            end
        endcase
    end

    // Offset-and-mirror mapping; blanking coordinates pass straight through.
    always_comb begin
        coord_e_c = {1'b0, coord};
        shifted_c = coord_e_c + {1'b0, act};
        wrapped_c = (shifted_c >= MAX_E) ? (shifted_c - MAX_E) : shifted_c;
        map_c     = coord;
        if (coord_e_c < MAX_E) begin
            map_c = mirror ? CW'(LAST_E - wrapped_c) : CW'(wrapped_c);
        end
    end

    // Offset state and registered output coordinate.
    always_ff @(posedge clk) begin
        if (reset) begin
            pend        <= '0;
            act         <= '0;
            bounce_down <= 1'b0;
            new_coord   <= '0;
        end else begin
            if (commit) begin
                act <= pend;
            end
            if (tick) begin
                pend        <= pend_nxt_c;
                bounce_down <= down_nxt_c;
            end
            new_coord <= map_c;
        end
    end

    assign off = act;

endmodule

// File: rtl/scroll_transformer.sv
// Two-axis frame-synchronous coordinate scroller.
module scroll_transformer
    import scroll_pkg::*;
#(
    parameter int unsigned CW       = 10,
    parameter int unsigned H_ACTIVE = 640,
    parameter int unsigned V_ACTIVE = 480,
    parameter int unsigned TICK_DIV = 400000,
    parameter int unsigned TICK_W   = 19,
    parameter int unsigned SW       = 4
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          vsync,
    input  logic          enable,
    input  logic          in_valid,
    input  logic [CW-1:0] x,
    input  logic [CW-1:0] y,
    input  logic [1:0]    mode_x,
    input  logic [1:0]    mode_y,
    input  logic          dir_x,
    input  logic          dir_y,
    input  logic [SW-1:0] step_x,
    input  logic [SW-1:0] step_y,
    input  logic          mirror_x,
    input  logic          mirror_y,
    output logic [CW-1:0] new_x,
    output logic [CW-1:0] new_y,
    output logic          out_valid,
    output logic [CW-1:0] off_x,
    output logic [CW-1:0] off_y,
    output logic          frame_commit
);

    logic div_tick_c;
    logic tick_c;
    logic commit_c;
    logic vsync_q;

    // Divider is held cleared while scrolling is disabled.
    mod_m_timer #(
        .N(TICK_W),
        .M(TICK_DIV)
    ) u_div (
        .clk       (clk),
        .reset     (reset | ~enable),
        .max_tick_c(div_tick_c)
    );

    assign tick_c   = div_tick_c & enable;
    assign commit_c = vsync & ~vsync_q;

    // vsync edge detector, commit pulse and valid pipeline.
    always_ff @(posedge clk) begin
        if (reset) begin
            vsync_q      <= 1'b0;
            frame_commit <= 1'b0;
            out_valid    <= 1'b0;
        end else begin
            vsync_q      <= vsync;
            frame_commit <= commit_c;
            out_valid    <= in_valid;
        end
    end

    scroll_axis #(
        .CW (CW),
        .MAX(H_ACTIVE),
        .SW (SW)
    ) u_axis_x (
        .clk      (clk),
        .reset    (reset),
        .tick     (tick_c),
        .commit   (commit_c),
        .mode     (mode_x),
        .dir      (dir_x),
        .step     (step_x),
        .mirror   (mirror_x),
        .coord    (x),
        .new_coord(new_x),
        .off      (off_x)
    );

    scroll_axis #(
        .CW (CW),
        .MAX(V_ACTIVE),
        .SW (SW)
    ) u_axis_y (
        .clk      (clk),
        .reset    (reset),
        .tick     (tick_c),
        .commit   (commit_c),
        .mode     (mode_y),
        .dir      (dir_y),
        .step     (step_y),
        .mirror   (mirror_y),
        .coord    (y),
        .new_coord(new_y),
        .off      (off_y)
    );

endmodule

// File: tb/tb_scroll_transformer.sv
// Directed self-checking bench for scroll_transformer (TICK_DIV = 4).
module tb_scroll_transformer;

    localparam int unsigned CW = 10;
    localparam int unsigned SW = 4;
    localparam int unsigned TD = 4;

    logic          clk;
    logic          reset;
    logic          vsync;
    logic          enable;
    logic          in_valid;
    logic [CW-1:0] x;
    logic [CW-1:0] y;
    logic [1:0]    mode_x;
    logic [1:0]    mode_y;
    logic          dir_x;
    logic          dir_y;
    logic [SW-1:0] step_x;
    logic [SW-1:0] step_y;
    logic          mirror_x;
    logic          mirror_y;
    logic [CW-1:0] new_x;
    logic [CW-1:0] new_y;
    logic          out_valid;
    logic [CW-1:0] off_x;
    logic [CW-1:0] off_y;
    logic          frame_commit;

    typedef struct {
        logic [CW-1:0] ex;
        logic [CW-1:0] ey;
        logic          ev;
    } exp_t;

    exp_t sb[$];

    int n_assert = 0;
    int n_fail   = 0;

    scroll_transformer #(
        .CW      (CW),
        .H_ACTIVE(640),
        .V_ACTIVE(480),
        .TICK_DIV(TD),
        .TICK_W  (19),
        .SW      (SW)
    ) dut (
        .clk         (clk),
        .reset       (reset),
        .vsync       (vsync),
        .enable      (enable),
        .in_valid    (in_valid),
        .x           (x),
        .y           (y),
        .mode_x      (mode_x),
        .mode_y      (mode_y),
        .dir_x       (dir_x),
        .dir_y       (dir_y),
        .step_x      (step_x),
        .step_y      (step_y),
        .mirror_x    (mirror_x),
        .mirror_y    (mirror_y),
        .new_x       (new_x),
        .new_y       (new_y),
        .out_valid   (out_valid),
        .off_x       (off_x),
        .off_y       (off_y),
        .frame_commit(frame_commit)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Hard time limit so the run can never hang.
    initial begin
        #1000000;
        $display("FAIL watchdog: observed timeout expected finish");
        $fatal(1, "watchdog expired");
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic cyc(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic do_reset();
        reset = 1'b1;
        cyc(2);
        reset = 1'b0;
    endtask

    // Exactly k divider ticks, then the divider is frozen again.
    task automatic ticks(input int k);
        enable = 1'b1;
        cyc(TD * k);
        enable = 1'b0;
    endtask

    task automatic commit_chk(input string tag, input int ex, input int ey);
        vsync = 1'b1;
        cyc(1);
        check({tag, "_pulse"}, 32'(frame_commit), 32'd1);
        check({tag, "_off_x"}, 32'(off_x), 32'(ex));
        check({tag, "_off_y"}, 32'(off_y), 32'(ey));
        vsync = 1'b0;
        cyc(1);
        check({tag, "_pulse_end"}, 32'(frame_commit), 32'd0);
    endtask

    // Drive one pixel, queue its expectation, compare one cycle later.
    task automatic pix(input string tag, input int px, input int py, input bit pv,
                       input int ex, input int ey);
        exp_t e;
        x        = CW'(px);
        y        = CW'(py);
        in_valid = pv;
        e.ex = CW'(ex);
        e.ey = CW'(ey);
        e.ev = pv;
        sb.push_back(e);
        cyc(1);
        n_assert++;
        assert (sb.size() != 0) else begin
            n_fail++;
            $error("FAIL %s_sb: observed empty expected entry", tag);
        end
        if (sb.size() != 0) begin
            e = sb.pop_front();
            check({tag, "_new_x"}, 32'(new_x), 32'(e.ex));
            check({tag, "_new_y"}, 32'(new_y), 32'(e.ey));
            check({tag, "_valid"}, 32'(out_valid), 32'(e.ev));
        end
    endtask

    initial begin
        int cnt;
        int bp;
        bit bd;

        reset = 1'b1; vsync = 1'b0; enable = 1'b0; in_valid = 1'b0;
        x = '0; y = '0; mode_x = 2'b00; mode_y = 2'b00;
        dir_x = 1'b0; dir_y = 1'b0; step_x = '0; step_y = '0;
        mirror_x = 1'b0; mirror_y = 1'b0;
        @(negedge clk);
        cyc(2);

        // Reset values
        check("rst_new_x", 32'(new_x), 32'd0);
        check("rst_new_y", 32'(new_y), 32'd0);
        check("rst_valid", 32'(out_valid), 32'd0);
        check("rst_off_x", 32'(off_x), 32'd0);
        check("rst_off_y", 32'(off_y), 32'd0);
        check("rst_commit", 32'(frame_commit), 32'd0);
        reset = 1'b0;
        cyc(1);

        // Wrap increment: 214 ticks of 3 -> 642 mod 640
        mode_x = 2'b01; step_x = 4'd3; dir_x = 1'b0;
        ticks(214);
        check("winc_pre_commit", 32'(off_x), 32'd0);
        commit_chk("winc", 2, 0);
        pix("winc_639", 639, 0, 1'b1, 1, 0);
        pix("winc_10", 10, 5, 1'b1, 12, 5);

        // Wrap decrement from 0
        do_reset();
        dir_x = 1'b1; step_x = 4'd5;
        ticks(1);
        commit_chk("wdec", 635, 0);
        pix("wdec_10", 10, 0, 1'b1, 5, 0);

        // Mid-frame tick does not move the active offset
        ticks(1);
        check("mid_frame", 32'(off_x), 32'd635);

        // Tick and vsync edge in the same cycle: pre-tick pend is committed
        enable = 1'b1;
        cyc(TD - 1);
        vsync = 1'b1;
        cyc(1);
        enable = 1'b0;
        vsync  = 1'b0;
        check("coinc_off_x", 32'(off_x), 32'd630);
        check("coinc_pulse", 32'(frame_commit), 32'd1);
        cyc(1);
        commit_chk("coinc_next", 625, 0);

        // vsync held high: one commit only
        vsync = 1'b1;
        cnt = 0;
        for (int i = 0; i < 100; i++) begin
            cyc(1);
            cnt += int'(frame_commit);
        end
        vsync = 1'b0;
        for (int i = 0; i < 2; i++) begin
            cyc(1);
            cnt += int'(frame_commit);
        end
        check("vs_hold_pulses", 32'(cnt), 32'd1);
        check("vs_hold_off_x", 32'(off_x), 32'd625);

        // Mirror, blanking and valid pipeline
        do_reset();
        mode_x = 2'b00; dir_x = 1'b0;
        mirror_x = 1'b1;
        pix("mir_x0", 0, 0, 1'b1, 639, 0);
        pix("blank_x700", 700, 0, 1'b0, 700, 0);
        pix("mir_x5", 5, 0, 1'b1, 634, 0);
        mirror_y = 1'b1;
        pix("mir_y0", 0, 0, 1'b1, 639, 479);
        pix("mir_y479", 0, 479, 1'b1, 639, 0);
        pix("blank_y500", 0, 500, 1'b1, 639, 500);
        mirror_x = 1'b0; mirror_y = 1'b0;
        pix("unmir", 3, 4, 1'b1, 3, 4);

        // Enable low freezes pend
        mode_x = 2'b01; step_x = 4'd10;
        ticks(10);
        commit_chk("to100", 100, 0);
        ticks(1);
        cyc(20);
        commit_chk("frozen", 110, 0);

        // Reset mid-scroll with vsync held high across release
        enable = 1'b1; in_valid = 1'b1; x = 10'd5; y = 10'd7;
        cyc(3);
        reset = 1'b1; vsync = 1'b1;
        cyc(1);
        check("mrst_new_x", 32'(new_x), 32'd0);
        check("mrst_new_y", 32'(new_y), 32'd0);
        check("mrst_valid", 32'(out_valid), 32'd0);
        check("mrst_off_x", 32'(off_x), 32'd0);
        check("mrst_off_y", 32'(off_y), 32'd0);
        check("mrst_commit", 32'(frame_commit), 32'd0);
        enable = 1'b0; in_valid = 1'b0;
        reset = 1'b0;
        cyc(1);
        check("rel_commit", 32'(frame_commit), 32'd1);
        vsync = 1'b0;
        cyc(1);

        // Bounce on y, step 7
        do_reset();
        mode_x = 2'b00; mode_y = 2'b10; step_y = 4'd7;
        bp = 0;
        bd = 1'b0;
        for (int t = 0; t < 145; t++) begin
            ticks(1);
            if (!bd) begin
                if (bp + 7 >= 479) begin
                    bp = 479;
                    bd = 1'b1;
                end else begin
                    bp += 7;
                end
            end else begin
                if (bp <= 7) begin
                    bp = 0;
                    bd = 1'b0;
                end else begin
                    bp -= 7;
                end
            end
            commit_chk("bounce", 0, bp);
            if (t == 68)  check("bounce_top", 32'(off_y), 32'd479);
            if (t == 69)  check("bounce_turn", 32'(off_y), 32'd472);
            if (t == 137) check("bounce_floor", 32'(off_y), 32'd0);
            if (t == 138) check("bounce_rise", 32'(off_y), 32'd7);
        end
        pix("bounce_y", 0, 10, 1'b1, 0, (10 + bp) % 480);

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule

// File: doc/scroll_transformer.md
# scroll_transformer

Two-axis, per-frame-synchronous coordinate scroller for the VGA demo pipeline. Maps raster coordinates (x, y) from the sync generator to shifted or mirrored source coordinates for the pattern or ROM stage. Each axis independently supports a static mode, a wrapping scroll mode and a bouncing (ping-pong) mode. Offsets advance on a divided tick and are committed only at the rising edge of vsync, so no frame tears.

## Interface
- CW, 10, coordinate width
- H_ACTIVE, 640, visible width; x range 0..H_ACTIVE-1
- V_ACTIVE, 480, visible height
- TICK_DIV, 400000, clk cycles per offset-update tick
- TICK_W, 19, divider counter width; 2^TICK_W ≥ TICK_DIV
- SW, 4, step width

Ports:
- clk  in  1  pixel clock
- reset  in  1  synchronous, active-high
- vsync  in  1  vertical sync, active-high level
- enable  in  1  1 = offsets advance on ticks
- in_valid  in  1  x/y qualifier
- x, y  in  CW  raster coordinates
- mode_x, mode_y  in  2  axis mode: 00 static, 01 wrap, 10 bounce, 11 treated as static
- dir_x, dir_y  in  1  wrap direction: 0 = increment, 1 = decrement
- step_x, step_y  in  SW  offset change per tick; must be < H_ACTIVE / V_ACTIVE
- mirror_x, mirror_y  in  1  mirror the axis after the offset is applied
- new_x, new_y  out  CW  transformed coordinates, registered
- out_valid  out  1  registered copy of in_valid
- off_x, off_y  out  CW  committed (active) offsets, for debug
- frame_commit  out  1  one-cycle pulse when offsets are committed

## Operation
- Divider: counts 0..TICK_DIV-1 and emits a tick on the wrap. While enable=0 it is cleared and held, and pending offsets freeze.
- Each axis has a pending offset (pend) and a committed offset (act), both in the range 0..MAX-1, where MAX is H_ACTIVE or V_ACTIVE.
- On a tick, pend updates by mode:
  - Static: unchanged.
  - Wrap, dir=0: pend+step; subtract MAX if the result is ≥ MAX.
  - Wrap, dir=1: pend−step; add MAX if the result is < 0. Use a CW+1-bit signed intermediate.
  - Bounce has an internal direction bit, up/down, reset to up:
    - up: if pend+step ≥ MAX-1, set pend=MAX-1 and direction=down; else pend += step.
    - down: if pend ≤ step, set pend=0 and direction=up; else pend -= step.
- Commit: vsync is registered as vsync_q. When vsync=1 and vsync_q=0, act ← pend and frame_commit pulses.
- Transform, for x < H_ACTIVE:
  - s = x + act_x in CW+1 bits; subtract H_ACTIVE if s ≥ H_ACTIVE.
  - If mirror_x, result = H_ACTIVE-1-s.
  - The y axis uses the same rule with V_ACTIVE.
- Blanking: coordinates ≥ MAX pass through unchanged, and mirror is not applied.
- Mode changes take effect on the next tick with the current pend. Bounce direction is kept across mode changes.

## Timing
- Latency: exactly 1 cycle from x/y/in_valid to new_x/new_y/out_valid. Throughput: 1 per clk.
- Reset values: new_x=new_y=0, out_valid=0, off_x=off_y=0, frame_commit=0. Internally pend=act=0, divider=0, bounce direction=up, vsync_q=0.
- Tick and commit in the same cycle: act takes the pre-tick pend. The tick result appears at the next commit.
- vsync held high: exactly one commit per rising edge.
- vsync high during reset release: vsync_q=0 after reset, so the first cycle with vsync=1 commits.
- Reset mid-frame: all state is cleared on the next clk edge and outputs read 0 the following cycle.
- mirror_* and act changes affect the output computed in the cycle after the change.

## Structure
- Package scroll_pkg holds MODE_STATIC, MODE_WRAP and MODE_BOUNCE as 2-bit localparams, and the mode_t typedef.
- Sub-module scroll_axis is instantiated twice (MAX = H_ACTIVE or V_ACTIVE). It contains pend, act, the bounce direction, the tick update and the registered transform/mirror.
- The top level contains the existing mod_m_timer divider (N=TICK_W, M=TICK_DIV), the vsync edge detector and the out_valid register.

## Test plan
Unless noted, the bench uses TICK_DIV=4.
- Wrap increment: mode_x=01, step_x=3, 214 ticks then vsync edge → off_x=2 (642 mod 640); input x=639 → new_x=1 one cycle later.
- Wrap decrement: dir_x=1, step_x=5 from 0, one tick then commit → off_x=635; x=10 → new_x=5.
- Bounce: mode_y=10, step_y=7 → pend climbs to 479, holds 479 for one tick, then descends 472, 465, …; at pend ≤ 7 it clamps to 0 and rises again. Check the sequence at each commit.
- Frame sync: ticks mid-frame leave off_x unchanged until the vsync rising edge. With tick and edge coincident, off_x = pre-tick value. vsync held high for 100 cycles gives one frame_commit pulse.
- Mirror/blanking: act_x=0, mirror_x=1, x=0 → new_x=639; x=700 → new_x=700; in_valid pattern 1,0,1 → out_valid 1,0,1 delayed by one cycle.
- Reset mid-scroll, enable=0: assert reset with off_x=100 → all outputs 0 the next cycle. With enable=0 for 20 cycles, pend is unchanged.
